// File: rtl/opb_regbank_pkg.sv
// rtl/opb_regbank_pkg.sv - shared types and OPB bit/byte-lane helpers for the register bank
package opb_regbank_pkg;

  localparam int OPB_DWIDTH = 32;

  typedef enum logic {IDLE, ACK} state_t;

  // OPB numbers bits MSB-first ([0:31]); user logic uses [31:0], so bus bit k is user bit 31-k.
  function automatic logic [OPB_DWIDTH-1:0] bus_to_user(input logic [0:OPB_DWIDTH-1] d);
    logic [OPB_DWIDTH-1:0] u;
    for (int k = 0; k < OPB_DWIDTH; k++) u[OPB_DWIDTH-1-k] = d[k];
    return u;
  endfunction

  function automatic logic [0:OPB_DWIDTH-1] user_to_bus(input logic [OPB_DWIDTH-1:0] u);
    logic [0:OPB_DWIDTH-1] d;
    for (int k = 0; k < OPB_DWIDTH; k++) d[k] = u[OPB_DWIDTH-1-k];
    return d;
  endfunction

  function automatic logic [OPB_DWIDTH-1:0] be_mask(input logic [0:3] be);
    logic [OPB_DWIDTH-1:0] m;
    for (int j = 0; j < 4; j++) m[31-8*j -: 8] = {8{be[j]}};
    return m;
  endfunction

  function automatic logic [OPB_DWIDTH-1:0] byte_merge(input logic [OPB_DWIDTH-1:0] old,
                                                       input logic [OPB_DWIDTH-1:0] data,
                                                       input logic [OPB_DWIDTH-1:0] mask);
    return (old & ~mask) | (data & mask);
  endfunction

endpackage

// File: rtl/opb_register_bank_ppc2simulink_if.sv
// rtl/opb_register_bank_ppc2simulink_if.sv - OPB master/slave signal bundle for the register bank
interface opb_register_bank_ppc2simulink_if
  import opb_regbank_pkg::*;
;
  logic [0:OPB_DWIDTH-1] OPB_ABus;
  logic [0:3]            OPB_BE;
  logic [0:OPB_DWIDTH-1] OPB_DBus;
  logic                  OPB_RNW;
  logic                  OPB_select;
  logic                  OPB_seqAddr;
  logic [0:OPB_DWIDTH-1] Sl_DBus;
  logic                  Sl_xferAck;
  logic                  Sl_errAck;
  logic                  Sl_retry;
  logic                  Sl_toutSup;

  modport master (
    output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );

  modport slave (
    input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
    output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
  );
endinterface

// File: rtl/opb_regbank_word.sv
// rtl/opb_regbank_word.sv - one 32-bit byte-enabled register, shadowed when OPB_REGBANK_SHADOW_EN is defined
module opb_regbank_word
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_mask,
  input  logic [31:0] wr_data,
  input  logic        commit,
  output logic [31:0] q,
  output logic [31:0] rd
);

`ifdef OPB_REGBANK_SHADOW_EN
  logic [31:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= RESET_VAL;
      q      <= RESET_VAL;
    end else begin
      if (wr_en) shadow <= byte_merge(shadow, wr_data, wr_mask);
      if (commit) q <= shadow;
    end
  end

  assign rd = shadow;
`else
  logic unused;
  assign unused = commit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RESET_VAL;
    else if (wr_en) q <= byte_merge(q, wr_data, wr_mask);
  end

  assign rd = q;
`endif

endmodule

// File: rtl/opb_register_bank_ppc2simulink.sv
// rtl/opb_register_bank_ppc2simulink.sv - OPB register bank feeding fabric; OPB_REGBANK_SHADOW_EN adds shadowed atomic commit
module opb_register_bank_ppc2simulink
  import opb_regbank_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR  = 32'h01104300,
  parameter logic [31:0] C_HIGHADDR  = 32'h011043FF,
  parameter int          C_NUM_REGS  = 8,
  parameter logic [63:0] C_RO_MASK   = 64'h0,
  parameter logic [31:0] C_RESET_VAL = 32'h0
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  opb_register_bank_ppc2simulink_if.slave bus,
  input  logic [32*C_NUM_REGS-1:0]     user_data_in,
  output logic [32*C_NUM_REGS-1:0]     user_data_out,
  output logic [C_NUM_REGS-1:0]        user_wr_strobe
);

  localparam logic [C_NUM_REGS-1:0] RO = C_RO_MASK[C_NUM_REGS-1:0];
`ifdef OPB_REGBANK_SHADOW_EN
  localparam logic [C_NUM_REGS-1:0] CTRL = C_NUM_REGS'(1) << (C_NUM_REGS - 1);
`else
  localparam logic [C_NUM_REGS-1:0] CTRL = '0;
`endif
  localparam logic [C_NUM_REGS-1:0] RW = ~(RO | CTRL);

  state_t                 state;
  logic                   ack;
  logic                   hit;
  logic                   start;
  logic                   commit;
  logic [31:0]            offset;
  logic [29:0]            idx;
  logic [31:0]            wr_data;
  logic [31:0]            wr_mask;
  logic [31:0]            rd_mux;
  logic [31:0]            rd_data;
  logic [C_NUM_REGS-1:0]  wr_sel;
  logic [31:0]            rd_word [C_NUM_REGS];
  logic                   unused;

  assign unused  = ^{bus.OPB_seqAddr, offset[1:0], user_data_in};
  assign offset  = bus.OPB_ABus - C_BASEADDR;
  assign idx     = offset[31:2];
  assign hit     = bus.OPB_select && (bus.OPB_ABus >= C_BASEADDR) && (bus.OPB_ABus <= C_HIGHADDR);
  assign start   = (state == IDLE) && hit;
  assign wr_data = bus_to_user(bus.OPB_DBus);
  assign wr_mask = be_mask(bus.OPB_BE);

  // Out-of-range indices match no word: no write, read value stays 0.
  always_comb begin
    wr_sel = '0;
    rd_mux = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx == 30'(i)) begin
        wr_sel[i] = start && !bus.OPB_RNW;
        rd_mux    = rd_word[i];
      end
    end
  end

  for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_word
    if (RO[i]) begin : g_ro
      assign rd_word[i]             = user_data_in[32*i +: 32];
      assign user_data_out[32*i +: 32] = '0;
    end else if (CTRL[i]) begin : g_ctrl
      assign rd_word[i]             = '0;
      assign user_data_out[32*i +: 32] = '0;
    end else begin : g_rw
      opb_regbank_word #(.RESET_VAL(C_RESET_VAL)) u_word (
        .clk     (OPB_Clk),
        .rst_n   (OPB_Rst),
        .wr_en   (wr_sel[i]),
        .wr_mask (wr_mask),
        .wr_data (wr_data),
        .commit  (commit),
        .q       (user_data_out[32*i +: 32]),
        .rd      (rd_word[i])
      );
    end
  end

`ifndef OPB_REGBANK_SHADOW_EN
  assign commit = 1'b0;
`endif

  always_ff @(posedge OPB_Clk or negedge OPB_Rst) begin
    if (!OPB_Rst) begin
      state          <= IDLE;
      ack            <= 1'b0;
      rd_data        <= '0;
      user_wr_strobe <= '0;
`ifdef OPB_REGBANK_SHADOW_EN
      commit         <= 1'b0;
`endif
    end else begin
      ack            <= 1'b0;
      rd_data        <= '0;
      user_wr_strobe <= '0;
`ifdef OPB_REGBANK_SHADOW_EN
      commit         <= 1'b0;
      if (commit) user_wr_strobe <= RW;
`endif
      case (state)
        IDLE: if (hit) begin
          state <= ACK;
          ack   <= 1'b1;
          if (bus.OPB_RNW) rd_data <= rd_mux;
`ifdef OPB_REGBANK_SHADOW_EN
          commit <= wr_sel[C_NUM_REGS-1] && wr_data[0];
`else
          user_wr_strobe <= wr_sel & RW;
`endif
        end
        ACK: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Sl_DBus    = user_to_bus(rd_data);
  assign bus.Sl_xferAck = ack;
  assign bus.Sl_errAck  = 1'b0;
  assign bus.Sl_retry   = 1'b0;
  assign bus.Sl_toutSup = 1'b0;

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
Parametrised successor to the single software register: a bank of C_NUM_REGS 32-bit OPB-mapped registers driving Simulink fabric logic. Runs fully synchronous to OPB_Clk; no user clock and no CDC. Adds byte-enable writes, per-register write strobes and read-only status words sourced from fabric. Sits on the PPC OPB bus beside the other yellow-block slaves.

Parameters:
C_BASEADDR, 32'h01104300, base byte address of the bank.
C_HIGHADDR, 32'h011043FF, top of the decoded window; must be ≥ C_BASEADDR + 4*C_NUM_REGS - 1.
C_NUM_REGS, 8, number of 32-bit words (1..64).
C_RO_MASK, 0, bit i = 1 makes word i read-only; reads return user_data_in word i.
C_RESET_VAL, 32'h0, reset value of every writable word.

Ports:
OPB_Clk  in  1  sole clock.
OPB_Rst  in  1  asynchronous, active-low reset (0 = reset).
OPB_ABus  in  [0:31]  byte address.
OPB_BE  in  [0:3]  byte enables; BE[0] selects DBus[0:7].
OPB_DBus  in  [0:31]  write data.
OPB_RNW  in  1  1 = read.
OPB_select  in  1  transfer request.
OPB_seqAddr  in  1  ignored.
Sl_DBus  out  [0:31]  read data; zero unless acking a read.
Sl_xferAck  out  1  one-cycle transfer acknowledge.
Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
user_data_in  in  [32*C_NUM_REGS-1:0]  status words; word i = bits [32i+31:32i].
user_data_out  out  [32*C_NUM_REGS-1:0]  register contents, same packing.
user_wr_strobe  out  [C_NUM_REGS-1:0]  one-cycle pulse per written word.

Behaviour:
- Bit mapping: OPB DBus[k] <-> user bit [31-k]; BE[j] covers user bits [31-8j:24-8j].
- Hit = OPB_select & C_BASEADDR ≤ ABus ≤ C_HIGHADDR; index = (ABus - C_BASEADDR) >> 2; ABus[30:31] ignored.
- FSM, 2 states: IDLE: on hit -> ACK; else stay. ACK: Sl_xferAck = 1 for exactly this cycle -> IDLE unconditionally. Fixed latency: ack in 2nd cycle after select rises. A still-asserted select in IDLE starts a new transfer, so the maximum rate is one ack per 2 cycles.
- Write: committed on the IDLE->ACK edge, for enabled bytes only, and only if index < C_NUM_REGS and the word is not RO. user_wr_strobe[index] pulses during the ACK cycle, also when BE = 0. No strobe for RO or out-of-range words.
- Read: Sl_DBus is registered on the IDLE->ACK edge. It returns user_data_out (RW) or user_data_in sampled that edge (RO). Out-of-range index returns 0. Sl_DBus = 0 in every non-ACK cycle and on write acks.
- Out-of-range index inside the window is still acked; never errAck.
- select dropping during ACK: ack still issued, FSM returns to IDLE; no abort.
- Reset (async assert, sync deassert is external): FSM = IDLE, Sl_xferAck = 0, Sl_DBus = 0, user_wr_strobe = 0, RW words = C_RESET_VAL, RO words of user_data_out = 0. Reset mid-transfer drops the ack; a write not yet committed is lost.

Optional Feature:
OPB_REGBANK_SHADOW_EN
- Defined: writes land in a shadow bank. user_data_out changes only when the bank commits. The bank commits when a write with DBus[31] = 1 (user bit 0) hits word C_NUM_REGS-1, which is a reserved control word, read as 0. All shadows copy to user_data_out the cycle after that ack, atomically. Reads of RW words return the shadow. user_wr_strobe pulses for all RW words on commit, not on individual writes.
- Undefined: no shadow; the behaviour is as above, and word C_NUM_REGS-1 is an ordinary register.

Decomposition:
- Package opb_regbank_pkg: state enum {IDLE, ACK}, OPB_DWIDTH = 32, and functions for the byte-lane mask and the bit-reverse mapping.
- One sub-module, opb_regbank_word: a single 32-bit register with byte-enable write, reset value and optional shadow. Instantiated once per RW word by generate.

Test Plan:
- Reset, then read all 8 words -> RW words = 0, RO words = user_data_in; every ack exactly 1 cycle, 2nd cycle after select.
- Write 0xDEADBEEF to word 3 with BE = 1111 -> user_data_out word 3 = 0xDEADBEEF, user_wr_strobe = 8'b0000_1000 for 1 cycle; read word 3 returns the same value.
- Write 0x11223344 to word 3 with BE = 0100 -> word 3 = 0xDE22BEEF.
- C_RO_MASK = 8'h80, user_data_in word 7 = 0xCAFE0001; write 0 to word 7 -> read returns 0xCAFE0001 and there is no strobe. Access at ABus = base+0x40 -> acked, reads 0, no state change.
- Select held high across 3 transfers -> acks at cycles 2, 4, 6; Sl_DBus = 0 between acks. Assert reset in an ACK cycle -> ack drops immediately, all outputs at reset values.
- With SHADOW_EN: write words 0 and 1 -> outputs unchanged; write 1 to word 7 -> both update in the same cycle, strobes on words 0–6.
